// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: funct3 codes, FSM states,
// and the store-lane, rejection and load-extension helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {CLEAR, IDLE} state_t;

    function automatic logic [3:0] byte_mask(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 4'b0001 << off;
            F3_H:    return 4'b0011 << off;
            F3_W:    return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    return {4{wd[7:0]}};
            F3_H:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic is_rejected(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic bad_f3;
        if (we)
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W});
        else
            bad_f3 = !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
        return bad_f3 || (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [2:0] f3,
                                                input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_BU:   return {24'b0, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_HU:   return {16'b0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port RAM with four byte-lane write enables; read is synchronous (read-first),
// one access per cycle, no backpressure.
module dmem_bank #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    mask,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [3:0][7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mask[i])
                mem[addr][i] <= wdata[8*i +: 8];
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32I load/store data memory with optional post-reset clear; load data and the
// reject pulse appear the cycle after acceptance; ready is low only while clearing/reset.
module dmem_lsu #(
    parameter int DATAMEM_DEPTH  = 4096,
    parameter int DATAMEM_ADDR_W = 14,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                      clk_70_mhz,
    input  logic                      rst_n,
    input  logic                      datamem_req,
    input  logic                      datamem_we,
    input  logic [2:0]                datamem_funct3,
    input  logic [DATAMEM_ADDR_W-1:0] datamem_addr,
    input  logic [31:0]               datamem_write_data,
    output logic                      datamem_ready,
    output logic                      datamem_rvalid,
    output logic [31:0]               datamem_data_out,
    output logic                      datamem_misaligned
);
    import dmem_pkg::*;

    localparam int WAW = $clog2(DATAMEM_DEPTH);

    state_t         state, state_nxt;
    logic [WAW-1:0] clr_cnt, clr_cnt_nxt;
    logic           ready_q, rvalid_q, misaligned_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;
    logic [31:0]    hold;
    logic           accept, reject;
    logic [1:0]     off;
    logic [WAW-1:0] bank_addr;
    logic [3:0]     bank_mask;
    logic [31:0]    bank_wdata, bank_rdata;

    assign off    = datamem_addr[1:0];
    assign accept = datamem_req && ready_q;
    assign reject = is_rejected(datamem_we, datamem_funct3, off);

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        bank_addr   = datamem_addr[WAW+1:2];
        bank_mask   = 4'b0000;
        bank_wdata  = store_lanes(datamem_funct3, datamem_write_data);
        case (state)
            CLEAR: begin
                bank_addr   = clr_cnt;
                bank_mask   = 4'b1111;
                bank_wdata  = '0;
                clr_cnt_nxt = clr_cnt + WAW'(1);
                if (&clr_cnt)
                    state_nxt = IDLE;
            end
            IDLE: begin
                if (accept && datamem_we && !reject)
                    bank_mask = byte_mask(datamem_funct3, off);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ready lags the state by one cycle so the first IDLE cycle still reports not-ready
    always_ff @(posedge clk_70_mhz) begin
        if (!rst_n) begin
            if (CLEAR_ON_RESET)
                state <= CLEAR;
            else
                state <= IDLE;
            clr_cnt      <= '0;
            ready_q      <= 1'b0;
            rvalid_q     <= 1'b0;
            misaligned_q <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            hold         <= '0;
        end else begin
            state        <= state_nxt;
            clr_cnt      <= clr_cnt_nxt;
            ready_q      <= (state == IDLE);
            rvalid_q     <= accept && !datamem_we && !reject;
            misaligned_q <= accept && reject;
            if (accept) begin
                f3_q  <= datamem_funct3;
                off_q <= off;
            end
            hold <= datamem_data_out;
        end
    end

    dmem_bank #(
        .DEPTH (DATAMEM_DEPTH),
        .AW    (WAW)
    ) u_bank (
        .clk   (clk_70_mhz),
        .addr  (bank_addr),
        .mask  (bank_mask),
        .wdata (bank_wdata),
        .rdata (bank_rdata)
    );

    assign datamem_ready      = ready_q;
    assign datamem_rvalid     = rvalid_q;
    assign datamem_misaligned = misaligned_q;
    assign datamem_data_out   = rvalid_q ? load_extend(bank_rdata, f3_q, off_q) : hold;

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: directed scenarios plus randomized traffic against a byte-array model.
module tb_dmem_lsu;

    localparam int DEPTH = 16;
    localparam int AW    = 6;
    localparam int NBYTE = DEPTH * 4;

    logic          clk_70_mhz = 1'b0;
    logic          rst_n = 1'b0;
    logic          datamem_req = 1'b0;
    logic          datamem_we = 1'b0;
    logic [2:0]    datamem_funct3 = 3'b000;
    logic [AW-1:0] datamem_addr = '0;
    logic [31:0]   datamem_write_data = '0;
    logic          datamem_ready, datamem_rvalid, datamem_misaligned;
    logic [31:0]   datamem_data_out;

    int checks = 0;
    int failures = 0;

    logic [7:0]  mm [NBYTE];
    logic [31:0] exp_dout;

    always #7 clk_70_mhz = ~clk_70_mhz;

    dmem_lsu #(
        .DATAMEM_DEPTH  (DEPTH),
        .DATAMEM_ADDR_W (AW),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk_70_mhz         (clk_70_mhz),
        .rst_n              (rst_n),
        .datamem_req        (datamem_req),
        .datamem_we         (datamem_we),
        .datamem_funct3     (datamem_funct3),
        .datamem_addr       (datamem_addr),
        .datamem_write_data (datamem_write_data),
        .datamem_ready      (datamem_ready),
        .datamem_rvalid     (datamem_rvalid),
        .datamem_data_out   (datamem_data_out),
        .datamem_misaligned (datamem_misaligned)
    );

    // Returns 1 = good load, 2 = rejected, 3 = good store
    function automatic int model_op(input bit we, input logic [2:0] f3, input int addr, input logic [31:0] wd);
        int a = addr % NBYTE;
        int size = 1 << f3[1:0];
        bit legal;
        logic [31:0] v;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal || (a % size) != 0)
            return 2;
        if (we) begin
            for (int k = 0; k < size; k++)
                mm[a + k] = wd[8*k +: 8];
            return 3;
        end
        v = 0;
        for (int k = 0; k < size; k++)
            v = v | (32'(mm[a + k]) << (8 * k));
        if (f3[2] == 1'b0 && size < 4 && v[8*size-1])
            v = v | (32'hFFFF_FFFF << (8 * size));
        exp_dout = v;
        return 1;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < NBYTE; i++)
            mm[i] = 8'h00;
    endtask

    // Drives one request from a negedge; returns at the next negedge, where its response is visible
    task automatic step(input bit req, input bit we, input logic [2:0] f3, input int addr,
                        input logic [31:0] wd, output int kind);
        datamem_req        = req;
        datamem_we         = we;
        datamem_funct3     = f3;
        datamem_addr       = AW'(addr);
        datamem_write_data = wd;
        kind = req ? model_op(we, f3, addr, wd) : 0;
        @(negedge clk_70_mhz);
        datamem_req = 1'b0;
    endtask

    task automatic test_reset();
        int kind;
        rst_n = 1'b0;
        repeat (3) @(negedge clk_70_mhz);
        checks++;
        if (datamem_ready !== 1'b0 || datamem_rvalid !== 1'b0 || datamem_misaligned !== 1'b0 ||
            datamem_data_out !== 32'h0) begin
            failures++;
            $display("FAIL reset_state ready=%b rvalid=%b mis=%b dout=%h, want 0/0/0/0",
                     datamem_ready, datamem_rvalid, datamem_misaligned, datamem_data_out);
        end
        datamem_req = 1'b1; datamem_we = 1'b0; datamem_funct3 = 3'b010; datamem_addr = '0;
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk_70_mhz); #1;
            checks++;
            if (datamem_ready !== 1'(i == 17) || datamem_rvalid !== 1'b0) begin
                failures++;
                $display("FAIL clear_ready edge=%0d ready=%b rvalid=%b want ready=%b rvalid=0",
                         i, datamem_ready, datamem_rvalid, 1'(i == 17));
            end
        end
        datamem_req = 1'b0;
        clear_model();
        exp_dout = 32'h0;
        @(negedge clk_70_mhz);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 3'b010, 4 * i, 32'h0, kind);
            checks++;
            if (datamem_rvalid !== 1'b1 || datamem_data_out !== 32'h0) begin
                failures++;
                $display("FAIL cleared_word idx=%0d rvalid=%b dout=%h want 1/00000000",
                         i, datamem_rvalid, datamem_data_out);
            end
        end
    endtask

    task automatic test_byte_merge();
        int kind;
        step(1'b1, 1'b1, 3'b010, 'h10, 32'h1122_3344, kind);
        step(1'b1, 1'b1, 3'b000, 'h11, 32'h0000_00AA, kind);
        step(1'b1, 1'b0, 3'b010, 'h10, 32'h0, kind);
        checks++;
        if (datamem_rvalid !== 1'b1 || datamem_data_out !== 32'h1122_AA44) begin
            failures++;
            $display("FAIL byte_merge rvalid=%b dout=%h want 1/1122aa44", datamem_rvalid, datamem_data_out);
        end
        step(1'b0, 1'b0, 3'b000, 0, 32'h0, kind);
        checks++;
        if (datamem_rvalid !== 1'b0 || datamem_data_out !== 32'h1122_AA44) begin
            failures++;
            $display("FAIL rvalid_pulse rvalid=%b dout=%h want 0/1122aa44", datamem_rvalid, datamem_data_out);
        end
    endtask

    task automatic test_half_ext();
        int kind;
        logic [2:0]  f3s [4] = '{3'b001, 3'b101, 3'b000, 3'b100};
        int          ads [4] = '{'h22, 'h22, 'h23, 'h22};
        logic [31:0] want [4] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0001};
        step(1'b1, 1'b1, 3'b001, 'h22, 32'h0000_8001, kind);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, f3s[i], ads[i], 32'h0, kind);
            checks++;
            if (datamem_rvalid !== 1'b1 || datamem_data_out !== want[i]) begin
                failures++;
                $display("FAIL half_ext case=%0d rvalid=%b dout=%h want 1/%h",
                         i, datamem_rvalid, datamem_data_out, want[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        int kind;
        logic [2:0] f3s [3] = '{3'b010, 3'b001, 3'b001};
        bit         wes [3] = '{1'b0, 1'b1, 1'b0};
        int         ads [3] = '{'h05, 'h07, 'h03};
        logic [31:0] held;
        step(1'b1, 1'b1, 3'b010, 'h04, 32'hCAFE_F00D, kind);
        step(1'b1, 1'b0, 3'b010, 'h10, 32'h0, kind);
        held = exp_dout;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, wes[i], f3s[i], ads[i], 32'hFFFF_FFFF, kind);
            checks++;
            if (kind != 2 || datamem_misaligned !== 1'b1 || datamem_rvalid !== 1'b0 ||
                datamem_data_out !== held) begin
                failures++;
                $display("FAIL misaligned case=%0d mis=%b rvalid=%b dout=%h want 1/0/%h",
                         i, datamem_misaligned, datamem_rvalid, datamem_data_out, held);
            end
        end
        step(1'b1, 1'b0, 3'b010, 'h04, 32'h0, kind);
        checks++;
        if (datamem_rvalid !== 1'b1 || datamem_misaligned !== 1'b0 || datamem_data_out !== 32'hCAFE_F00D) begin
            failures++;
            $display("FAIL misaligned_untouched rvalid=%b mis=%b dout=%h want 1/0/cafef00d",
                     datamem_rvalid, datamem_misaligned, datamem_data_out);
        end
    endtask

    task automatic test_back_to_back();
        int kind;
        int streak = 0;
        logic [31:0] val = $urandom;
        step(1'b1, 1'b1, 3'b010, 'h00, val, kind);
        step(1'b1, 1'b0, 3'b010, 'h00, 32'h0, kind);
        checks++;
        if (datamem_rvalid !== 1'b1 || datamem_data_out !== val) begin
            failures++;
            $display("FAIL store_then_load rvalid=%b dout=%h want 1/%h", datamem_rvalid, datamem_data_out, val);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, 3'b010, 4 * $urandom_range(0, DEPTH - 1), 32'h0, kind);
            if (datamem_rvalid === 1'b1) streak++;
            checks++;
            if (datamem_rvalid !== 1'b1 || datamem_data_out !== exp_dout) begin
                failures++;
                $display("FAIL stream_load idx=%0d rvalid=%b dout=%h want 1/%h",
                         i, datamem_rvalid, datamem_data_out, exp_dout);
            end
        end
        checks++;
        if (streak != 8) begin
            failures++;
            $display("FAIL stream_streak got=%0d want 8", streak);
        end
    endtask

    task automatic test_random();
        int kind;
        bit req, we;
        logic [2:0] f3;
        int addr;
        for (int n = 0; n < 300; n++) begin
            req  = ($urandom_range(0, 9) < 8);
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, NBYTE - 1);
            if ($urandom_range(0, 2) != 0) addr = addr & ~3;
            checks++;
            if (datamem_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_ready n=%0d ready=%b want 1", n, datamem_ready);
            end
            step(req, we, f3, addr, $urandom, kind);
            checks++;
            if (datamem_rvalid !== 1'(kind == 1) || datamem_misaligned !== 1'(kind == 2) ||
                datamem_data_out !== exp_dout) begin
                failures++;
                $display("FAIL rand_resp n=%0d we=%b f3=%0d addr=%h rvalid=%b mis=%b dout=%h want %b/%b/%h",
                         n, we, f3, addr, datamem_rvalid, datamem_misaligned, datamem_data_out,
                         1'(kind == 1), 1'(kind == 2), exp_dout);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int kind;
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 3'b010, 4 * i, 32'hA5A5_0000 | 32'(i), kind);
        @(posedge clk_70_mhz); #1;
        datamem_req = 1'b1; datamem_we = 1'b1; datamem_funct3 = 3'b010;
        datamem_addr = AW'(4 * $urandom_range(0, DEPTH - 1)); datamem_write_data = 32'hDEAD_BEEF;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_70_mhz);
        #1 rst_n = 1'b1;
        repeat (7) @(posedge clk_70_mhz);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk_70_mhz);
        #1 rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk_70_mhz); #1;
            checks++;
            if (datamem_ready !== 1'(i == 17) || datamem_rvalid !== 1'b0 || datamem_misaligned !== 1'b0) begin
                failures++;
                $display("FAIL reclear_ready edge=%0d ready=%b rvalid=%b mis=%b want %b/0/0",
                         i, datamem_ready, datamem_rvalid, datamem_misaligned, 1'(i == 17));
            end
        end
        datamem_req = 1'b0;
        clear_model();
        exp_dout = 32'h0;
        @(negedge clk_70_mhz);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 3'b010, 4 * i, 32'h0, kind);
            checks++;
            if (datamem_rvalid !== 1'b1 || datamem_data_out !== 32'h0) begin
                failures++;
                $display("FAIL reclear_word idx=%0d rvalid=%b dout=%h want 1/00000000",
                         i, datamem_rvalid, datamem_data_out);
            end
        end
    endtask

    initial begin
        exp_dout = 32'h0;
        clear_model();
        test_reset();
        test_byte_merge();
        test_half_ext();
        test_misaligned();
        test_back_to_back();
        test_random();
        test_reset_mid_clear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

Byte-addressed, parametrised data memory for the single-cycle RISC-V core. It replaces the word-only data memory with RV32I load/store semantics: LB/LH/LW/LBU/LHU and SB/SH/SW, byte-lane write masking, sign/zero extension, and misalignment detection. It uses a req/ready handshake and an optional post-reset memory-clear sequence. The block sits between the execute stage's address/store-data outputs and the write-back mux.

## Interface
- `DATAMEM_DEPTH`, 4096: number of 32-bit words; must be a power of two.
- `DATAMEM_ADDR_W`, 14: byte-address width, equal to log2(`DATAMEM_DEPTH`) + 2.
- `CLEAR_ON_RESET`, 1: when 1, every word is zeroed after reset release before the first access is accepted.
- `clk_70_mhz`, in, 1: single clock, all logic on its rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `datamem_req`, in, 1: access request.
- `datamem_we`, in, 1: 1 = store, 0 = load.
- `datamem_funct3`, in, 3: RV32I funct3 of the load or store.
- `datamem_addr`, in, `DATAMEM_ADDR_W`: byte address.
- `datamem_write_data`, in, 32: store data, right-aligned (rs2).
- `datamem_ready`, out, 1: block can accept a request this cycle.
- `datamem_rvalid`, out, 1: one-cycle pulse; load data valid.
- `datamem_data_out`, out, 32: extended load result; holds its value until the next valid load.
- `datamem_misaligned`, out, 1: one-cycle pulse; the accepted request was rejected.

## Operation
- Accept condition: `datamem_req && datamem_ready`. All other cycles are idle and leave memory unchanged.
- States:
  - CLEAR: write 0 to word `clr_cnt`, then increment it; `ready` = 0. After the write to word `DATAMEM_DEPTH`-1, go to IDLE.
  - IDLE: `ready` = 1.
- Reset state:
  - Reset enters CLEAR when `CLEAR_ON_RESET` = 1, otherwise IDLE.
  - Reset at any point, including mid-clear, restarts from `clr_cnt` = 0.
- Word index = `addr[ADDR_W-1:2]`; byte offset = `addr[1:0]`.
- Store:
  - SB: mask = 0001 << off; data = {4{wd[7:0]}}.
  - SH: mask = 0011 << off; data = {2{wd[15:0]}}.
  - SW: mask = 1111; data = wd.
  - Only masked byte lanes change.
- Load:
  - Read the whole word.
  - Register funct3 and offset alongside the read.
  - Next cycle, select the byte or half at the registered offset and extend it: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.
- Rejection conditions:
  - Half access with `off[0]` = 1.
  - Word access with `off` ≠ 0.
  - Load funct3 ∈ {011, 110, 111}.
  - Store funct3 ∉ {000, 001, 010}.
- Rejected request behaviour:
  - No lanes are written.
  - `rvalid` stays 0 and `data_out` is unchanged.
  - `misaligned` pulses in the cycle after acceptance.
- Reset values: `ready` = 0 (the first IDLE cycle raises it), `rvalid` = 0, `misaligned` = 0, `data_out` = 0.
- Memory contents are not reset except by CLEAR.

## Timing
- Store accepted at edge N: the lanes are written at edge N. A load of the same word accepted at N+1 returns the new data.
- Load accepted at edge N: `rvalid` = 1 and `data_out` are valid in cycle N+1, for exactly one cycle.
- Back-to-back accesses, in any load/store mix, are accepted every cycle with no bubbles.
- The port is single, so there is one operation per cycle and no read/write collision.
- CLEAR duration:
  - With `CLEAR_ON_RESET` = 1, `ready` rises `DATAMEM_DEPTH` + 1 cycles after the first cycle with `rst_n` = 1.
  - With `CLEAR_ON_RESET` = 0, `ready` rises in the first cycle after release.
- `req` during CLEAR or reset is ignored, not queued.
- Address wrap: the word index is taken modulo `DATAMEM_DEPTH` (upper bits truncated).

## Structure
- `dmem_pkg` holds:
  - funct3 constants `F3_B`=000, `F3_H`=001, `F3_W`=010, `F3_BU`=100, `F3_HU`=101;
  - the state enum {CLEAR, IDLE};
  - byte-mask and extend helper functions.
- Sub-module `dmem_bank` is a 4-lane byte-write-enable synchronous-read RAM (depth, mask, wdata, rdata) so synthesis infers block RAM. `dmem_lsu` contains the FSM, clear counter, lane alignment, response register and extension logic.

## Test plan
- Reset with `CLEAR_ON_RESET`=1, depth 16:
  - `ready` must be 0 for 17 cycles after release, then 1.
  - LW of any address must then return 0x00000000.
- SW 0x11223344 @0x10, then SB 0xAA @0x11, then LW @0x10:
  - must return 0x1122AA44, `rvalid` one cycle after acceptance.
- SH 0x8001 @0x22, then loads:
  - LH @0x22 → 0xFFFF8001.
  - LHU @0x22 → 0x00008001.
  - LB @0x23 → 0xFFFFFF80.
  - LBU @0x22 → 0x00000001.
- Misaligned accesses: LW @0x05, SH @0x07, LH @0x03:
  - each pulses `misaligned`, gives no `rvalid`, and leaves `data_out` unchanged.
  - A following LW @0x04 must show the word unmodified.
- Streaming: SW @0x00 then LW @0x00 on consecutive cycles, followed by 8 back-to-back loads:
  - the first load returns the stored value;
  - 8 consecutive `rvalid` pulses with no gaps.
- Reset mid-CLEAR: assert `rst_n`=0 at clear count 7:
  - after release, CLEAR runs the full depth again;
  - `req` is ignored throughout.
